qbus_tty: RTL and testbench

Synthesizable DL11-style console terminal slave for the am4 native QBUS; it replaces the behavioural terminal model used in simulation.
- Decodes the four-register block at BASE_ADDR (RCSR, RBUF, XCSR, XBUF) on the inverted multiplexed bus and answers with rply_n.
- Raises virq_n and supplies vectors during IAKO.
- Serializes and deserializes 8N1 async data on txd/rxd.
- Sits directly downstream of the CPU bus pins, alongside the RAM decoder.

---
 rtl/qbus_tty_pkg.sv | 23 ++
 rtl/qbus_tty_uart.sv | 135 +++++++++++++
 rtl/qbus_tty.sv | 190 +++++++++++++++++++
 tb/tb_qbus_tty.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_tty_pkg.sv
// Shared definitions for the qbus_tty console: register offsets, CSR bit
// positions and the bus / UART state encodings.
package qbus_tty_pkg;
    localparam logic [2:0] OFF_RCSR = 3'd0;
    localparam logic [2:0] OFF_RBUF = 3'd2;
    localparam logic [2:0] OFF_XCSR = 3'd4;
    localparam logic [2:0] OFF_XBUF = 3'd6;

    localparam int CSR_DONE = 7;
    localparam int CSR_IE   = 6;
    localparam int CSR_ERR  = 15;

    typedef enum logic [1:0] {BUS_IDLE, BUS_RD, BUS_WR, BUS_VEC} bus_state_e;
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

    function automatic logic [15:0] csr_word(input logic flag, input logic ie);
        logic [15:0] w;
        w           = '0;
        w[CSR_DONE] = flag;
        w[CSR_IE]   = ie;
        return w;
    endfunction
endpackage

// File: rtl/qbus_tty_uart.sv
// 8N1 transmitter and receiver with independent baud counters.
// RX re-checks the start bit half a bit after the falling edge.
module qbus_tty_uart
    import qbus_tty_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_strobe,
    output logic [7:0] rx_data
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] MID  = CW'(BAUD_DIV / 2 - 1);

    uart_state_e   tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_dat_q, rx_dat_d;
    logic          txd_q, txd_d, rx_stb_q, rx_stb_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = (tx_cnt_q == LAST) ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        txd_d    = txd_q;
        case (tx_st_q)
            U_IDLE: begin
                tx_cnt_d = '0;
                if (tx_load) begin
                    tx_st_d = U_START;
                    tx_sh_d = tx_data;
                    txd_d   = 1'b0;
                end
            end
            U_START: if (tx_cnt_q == LAST) begin
                tx_st_d  = U_DATA;
                tx_bit_d = '0;
                txd_d    = tx_sh_q[0];
                tx_sh_d  = tx_sh_q >> 1;
            end
            U_DATA: if (tx_cnt_q == LAST) begin
                if (tx_bit_q == 3'd7) begin
                    tx_st_d = U_STOP;
                    txd_d   = 1'b1;
                end else begin
                    txd_d    = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            default: if (tx_cnt_q == LAST) tx_st_d = U_IDLE;
        endcase
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = (rx_cnt_q == LAST) ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_dat_d = rx_dat_q;
        rx_stb_d = 1'b0;
        case (rx_st_q)
            U_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s_q) rx_st_d = U_START;
            end
            U_START: if (rx_cnt_q == MID) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s_q ? U_IDLE : U_DATA;
            end
            U_DATA: if (rx_cnt_q == LAST) begin
                rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_st_d = U_STOP;
            end
            default: if (rx_cnt_q == LAST) begin
                rx_st_d = U_IDLE;
                // A low stop bit is a framing error: drop the character.
                if (rx_s_q) begin
                    rx_stb_d = 1'b1;
                    rx_dat_d = rx_sh_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q   <= U_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            txd_q     <= 1'b1;
            rx_st_q   <= U_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_dat_q  <= '0;
            rx_stb_q  <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            txd_q     <= txd_d;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_dat_q  <= rx_dat_d;
            rx_stb_q  <= rx_stb_d;
            rx_meta_q <= rxd;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign tx_busy   = (tx_st_q != U_IDLE);
    assign txd       = txd_q;
    assign rx_strobe = rx_stb_q;
    assign rx_data   = rx_dat_q;
endmodule

// File: rtl/qbus_tty.sv
// DL11-style console slave on the inverted QBUS: RCSR/RBUF/XCSR/XBUF, vectored
// interrupts with daisy chain. Define QBUS_TTY_LOOP_EN to loop txd into the receiver.
module qbus_tty
    import qbus_tty_pkg::*;
#(
    parameter int          BAUD_DIV  = 434,
    parameter logic [15:0] BASE_ADDR = 16'o177560,
    parameter logic [15:0] RX_VECTOR = 16'o000060,
    parameter logic [15:0] TX_VECTOR = 16'o000064
) (
    input  logic        pin_clk,
    input  logic        pin_init_n,
    input  logic        sync_n,
    input  logic        din_n,
    input  logic        dout_n,
    input  logic        wtbt_n,
    input  logic        iako_n,
    input  logic [15:0] ad_in_n,
    output logic [15:0] ad_out_n,
    output logic        ad_oe,
    output logic        rply_n,
    output logic        virq_n,
    output logic        iako_out_n,
    input  logic        rxd,
    output logic        txd
);
    logic [1:0]  sync_ff_q, din_ff_q, dout_ff_q, iako_ff_q;
    logic        sync_s, din_s, dout_s, iako_s, addr_vld, sel, req_any;
    logic        sync_prev_q, byte_q;
    logic [15:0] addr_q, out_q, out_d, rd_word;
    logic [2:0]  reg_off;
    bus_state_e  state_q, state_d;
    logic        rply_q, rply_d, iako_out_q, iako_out_d;
    logic        rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, tx_rdy_q, tx_rdy_d;
    logic        rx_done_q, rx_done_d, rx_err_q, rx_err_d;
    logic        rx_req_q, rx_req_d, tx_req_q, tx_req_d, rx_lvl_q, tx_lvl_q;
    logic [7:0]  rbuf_q, rbuf_d, uart_rx_data;
    logic        tx_load, tx_busy, uart_rxd, uart_rx_strobe;

    assign sync_s   = sync_ff_q[1];
    assign din_s    = din_ff_q[1];
    assign dout_s   = dout_ff_q[1];
    assign iako_s   = iako_ff_q[1];
    assign addr_vld = sync_s && sync_prev_q;
    assign sel      = (addr_q[15:3] == BASE_ADDR[15:3]);
    assign reg_off  = {addr_q[2:1], 1'b0};
    assign req_any  = rx_req_q || tx_req_q;

    always_comb begin
        case (reg_off)
            OFF_RCSR: rd_word = csr_word(rx_done_q, rx_ie_q);
            OFF_RBUF: rd_word = {rx_err_q, 7'b0, rbuf_q};
            OFF_XCSR: rd_word = csr_word(tx_rdy_q, tx_ie_q);
            default:  rd_word = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        rx_ie_d   = rx_ie_q;
        tx_ie_d   = tx_ie_q;
        rx_done_d = rx_done_q;
        rx_err_d  = rx_err_q;
        rbuf_d    = rbuf_q;
        tx_load   = 1'b0;
        rx_req_d  = rx_req_q || (rx_done_q && rx_ie_q && !rx_lvl_q);
        tx_req_d  = tx_req_q || (tx_rdy_q && tx_ie_q && !tx_lvl_q);
        case (state_q)
            BUS_IDLE: begin
                if (addr_vld && sel && din_s) begin
                    state_d = BUS_RD;
                    out_d   = rd_word;
                    if (reg_off == OFF_RBUF) begin
                        rx_done_d = 1'b0;
                        rx_err_d  = 1'b0;
                    end
                end else if (addr_vld && sel && dout_s) begin
                    state_d = BUS_WR;
                    if (!(byte_q && addr_q[0])) begin
                        case (reg_off)
                            OFF_RCSR: rx_ie_d = ~ad_in_n[CSR_IE];
                            OFF_XCSR: tx_ie_d = ~ad_in_n[CSR_IE];
                            OFF_XBUF: tx_load = tx_rdy_q;
                            default:  ;
                        endcase
                    end
                end else if (iako_s && din_s && req_any) begin
                    state_d = BUS_VEC;
                    if (rx_req_q) begin
                        out_d    = RX_VECTOR;
                        rx_req_d = 1'b0;
                    end else begin
                        out_d    = TX_VECTOR;
                        tx_req_d = 1'b0;
                    end
                end
            end
            BUS_RD:  if (!din_s || !sync_s) state_d = BUS_IDLE;
            BUS_WR:  if (!dout_s || !sync_s) state_d = BUS_IDLE;
            // IAK cycles run without SYNC, so only DIN ends them.
            default: if (!din_s) state_d = BUS_IDLE;
        endcase
        // A completing character beats a simultaneous RBUF read.
        if (uart_rx_strobe) begin
            rx_err_d  = rx_err_d || rx_done_d;
            rx_done_d = 1'b1;
            rbuf_d    = uart_rx_data;
        end
        tx_rdy_d = tx_load ? 1'b0 : (tx_rdy_q || !tx_busy);
        if (!rx_ie_q) rx_req_d = 1'b0;
        if (!tx_ie_q) tx_req_d = 1'b0;
        rply_d     = !(state_q != BUS_IDLE && state_d != BUS_IDLE);
        iako_out_d = !(iako_s && !req_any && state_q != BUS_VEC && state_d != BUS_VEC);
    end

    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            sync_ff_q   <= '0;
            din_ff_q    <= '0;
            dout_ff_q   <= '0;
            iako_ff_q   <= '0;
            sync_prev_q <= 1'b0;
            addr_q      <= '0;
            byte_q      <= 1'b0;
            state_q     <= BUS_IDLE;
            out_q       <= '0;
            rply_q      <= 1'b1;
            iako_out_q  <= 1'b1;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            tx_rdy_q    <= 1'b1;
            rx_done_q   <= 1'b0;
            rx_err_q    <= 1'b0;
            rbuf_q      <= '0;
            rx_req_q    <= 1'b0;
            tx_req_q    <= 1'b0;
            rx_lvl_q    <= 1'b0;
            tx_lvl_q    <= 1'b0;
        end else begin
            sync_ff_q   <= {sync_ff_q[0], ~sync_n};
            din_ff_q    <= {din_ff_q[0], ~din_n};
            dout_ff_q   <= {dout_ff_q[0], ~dout_n};
            iako_ff_q   <= {iako_ff_q[0], ~iako_n};
            sync_prev_q <= sync_s;
            if (sync_s && !sync_prev_q) begin
                addr_q <= ~ad_in_n;
                byte_q <= ~wtbt_n;
            end
            state_q     <= state_d;
            out_q       <= out_d;
            rply_q      <= rply_d;
            iako_out_q  <= iako_out_d;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
            tx_rdy_q    <= tx_rdy_d;
            rx_done_q   <= rx_done_d;
            rx_err_q    <= rx_err_d;
            rbuf_q      <= rbuf_d;
            rx_req_q    <= rx_req_d;
            tx_req_q    <= tx_req_d;
            rx_lvl_q    <= rx_done_q && rx_ie_q;
            tx_lvl_q    <= tx_rdy_q && tx_ie_q;
        end
    end

`ifdef QBUS_TTY_LOOP_EN
    assign uart_rxd = txd;
`else
    assign uart_rxd = rxd;
`endif

    qbus_tty_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (pin_clk),
        .rst_n     (pin_init_n),
        .tx_load   (tx_load),
        .tx_data   (~ad_in_n[7:0]),
        .tx_busy   (tx_busy),
        .txd       (txd),
        .rxd       (uart_rxd),
        .rx_strobe (uart_rx_strobe),
        .rx_data   (uart_rx_data)
    );

    assign ad_oe      = (state_q == BUS_RD) || (state_q == BUS_VEC);
    assign ad_out_n   = ad_oe ? ~out_q : 16'hFFFF;
    assign rply_n     = rply_q;
    assign virq_n     = !req_any;
    assign iako_out_n = iako_out_q;
endmodule

// File: tb/tb_qbus_tty.sv
// Self-checking bench for qbus_tty: bus transactions, IAK, TX waveform and RX
// frames compared against a register-level model of the console.
module tb_qbus_tty;
    localparam int          B     = 16;
    localparam logic [15:0] BASE  = 16'o177560;
    localparam logic [15:0] RCSR  = BASE;
    localparam logic [15:0] RBUF  = BASE + 16'd2;
    localparam logic [15:0] XCSR  = BASE + 16'd4;
    localparam logic [15:0] XBUF  = BASE + 16'd6;

    logic        clk = 1'b0;
    logic        init_n, sync_n, din_n, dout_n, wtbt_n, iako_n, rxd;
    logic [15:0] ad_in_n, ad_out_n;
    logic        ad_oe, rply_n, virq_n, iako_out_n, txd;
    int          checks = 0;
    int          errors = 0;

    // Reference model of the receiver-visible state.
    logic       m_done, m_err, m_ie;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    qbus_tty #(.BAUD_DIV(B)) dut (
        .pin_clk(clk), .pin_init_n(init_n), .sync_n(sync_n), .din_n(din_n),
        .dout_n(dout_n), .wtbt_n(wtbt_n), .iako_n(iako_n), .ad_in_n(ad_in_n),
        .ad_out_n(ad_out_n), .ad_oe(ad_oe), .rply_n(rply_n), .virq_n(virq_n),
        .iako_out_n(iako_out_n), .rxd(rxd), .txd(txd)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rply(input logic level, output bit ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rply_n === level) begin ok = 1; break; end
        end
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bit ok1, ok2;
        ad_in_n = ~a; wtbt_n = 1'b1; clks(1);
        sync_n = 1'b0; clks(4);
        ad_in_n = '1; din_n = 1'b0;
        wait_rply(1'b0, ok1);
        d = ad_oe ? ~ad_out_n : 16'hDEAD;
        din_n = 1'b1;
        wait_rply(1'b1, ok2);
        sync_n = 1'b1; clks(3);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL bus_read_reply addr=%o got rply timeout, need reply", a);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic byt);
        bit ok1, ok2;
        ad_in_n = ~a; wtbt_n = ~byt; clks(1);
        sync_n = 1'b0; clks(4);
        ad_in_n = ~d; wtbt_n = 1'b1; dout_n = 1'b0;
        wait_rply(1'b0, ok1);
        dout_n = 1'b1;
        wait_rply(1'b1, ok2);
        sync_n = 1'b1; ad_in_n = '1; clks(3);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL bus_write_reply addr=%o got rply timeout, need reply", a);
        end
    endtask

    task automatic iak(output logic [15:0] v);
        bit ok1, ok2;
        iako_n = 1'b0; din_n = 1'b0;
        wait_rply(1'b0, ok1);
        v = ad_oe ? ~ad_out_n : 16'hDEAD;
        din_n = 1'b1; iako_n = 1'b1;
        wait_rply(1'b1, ok2);
        clks(3);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL iak_reply got rply timeout, need reply");
        end
    endtask

    // Drive one 8N1 frame on rxd and update the model with the receive rules.
    task automatic send_rx(input logic [7:0] c, input logic stop);
        logic [9:0] fr;
        fr = {stop, c, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i]; clks(B);
        end
        rxd = 1'b1; clks(B);
        if (stop) begin
            m_err  = m_err | m_done;
            m_done = 1'b1;
            m_data = c;
        end
    endtask

    // Watch txd for one frame; optionally measure the start bit (needs c[0]=1).
    task automatic check_tx_frame(input logic [7:0] c, input bit measure);
        logic [9:0] fr;
        bit         seen;
        int         n, first;
        fr = {1'b1, c, 1'b0};
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tx_start got txd idle, need start bit");
            return;
        end
        first = 0;
        if (measure) begin
            n = 0;
            while (txd === 1'b0 && n < 4 * B) begin n++; @(negedge clk); end
            checks++;
            if (n !== B) begin
                errors++;
                $display("FAIL tx_start_width got %0d clks, need %0d", n, B);
            end
            first = 1;
        end
        clks(B / 2);
        for (int i = first; i < 10; i++) begin
            checks++;
            if (txd !== fr[i]) begin
                errors++;
                $display("FAIL tx_bit%0d char=%h got %b, need %b", i, c, txd, fr[i]);
            end
            if (i < 9) clks(B);
        end
    endtask

    task automatic test_reset;
        logic [15:0] d;
        #1;
        checks++;
        if ({ad_oe, ad_out_n, rply_n, virq_n, iako_out_n, txd} !== {1'b0, 16'hFFFF, 4'b1111}) begin
            errors++;
            $display("FAIL reset_outputs got oe=%b ad=%h rply=%b virq=%b iako=%b txd=%b, need 0 ffff 1 1 1 1",
                     ad_oe, ad_out_n, rply_n, virq_n, iako_out_n, txd);
        end
        init_n = 1'b1; clks(4);
        bus_read(XCSR, d);
        checks++;
        if (d !== 16'o000200) begin errors++; $display("FAIL reset_xcsr got %o, need 000200", d); end
        bus_read(RCSR, d);
        checks++;
        if (d !== 16'o000000) begin errors++; $display("FAIL reset_rcsr got %o, need 000000", d); end
        bus_read(RBUF, d);
        checks++;
        if (d !== 16'o000000) begin errors++; $display("FAIL reset_rbuf got %o, need 000000", d); end
    endtask

    task automatic test_tx;
        logic [15:0] d;
        logic [7:0]  c;
        fork
            check_tx_frame(8'o101, 1);
            begin
                bus_write(XBUF, 16'o000101, 1'b0);
                bus_read(XCSR, d);
                checks++;
                if (d !== 16'o000000) begin errors++; $display("FAIL tx_busy_xcsr got %o, need 000000", d); end
            end
        join
        clks(B);
        bus_read(XCSR, d);
        checks++;
        if (d !== 16'o000200) begin errors++; $display("FAIL tx_done_xcsr got %o, need 000200", d); end
        for (int k = 0; k < 3; k++) begin
            c = 8'($urandom);
            fork
                check_tx_frame(c, 0);
                bus_write(XBUF, {8'h00, c}, 1'b0);
            join
            clks(B);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        logic [7:0]  c1, c2;
        bit          low;
        c1 = 8'($urandom); c2 = ~c1;
        fork
            check_tx_frame(c1, 0);
            begin
                bus_write(XBUF, {8'h00, c1}, 1'b0);
                bus_write(XBUF, {8'h00, c2}, 1'b0);
            end
        join
        clks(B);
        bus_read(XCSR, d);
        checks++;
        if (d !== 16'o000200) begin errors++; $display("FAIL b2b_xcsr got %o, need 000200", d); end
        low = 0;
        for (int i = 0; i < 11 * B; i++) begin @(negedge clk); if (txd !== 1'b1) low = 1; end
        checks++;
        if (low) begin errors++; $display("FAIL b2b_second_ignored got extra frame, need idle txd"); end
    endtask

    task automatic test_tx_irq;
        logic [15:0] v;
        logic [7:0]  c;
        bus_write(XCSR, 16'o000100, 1'b0); clks(2);
        checks++;
        if (virq_n !== 1'b0) begin errors++; $display("FAIL txirq_ie_set got virq_n=%b, need 0", virq_n); end
        iak(v);
        checks++;
        if (v !== 16'o000064) begin errors++; $display("FAIL txirq_vector got %o, need 000064", v); end
        clks(2);
        checks++;
        if (virq_n !== 1'b1) begin errors++; $display("FAIL txirq_served got virq_n=%b, need 1", virq_n); end
        c = 8'($urandom);
        fork
            check_tx_frame(c, 0);
            bus_write(XBUF, {8'h00, c}, 1'b0);
        join
        clks(B);
        checks++;
        if (virq_n !== 1'b0) begin errors++; $display("FAIL txirq_ready_rise got virq_n=%b, need 0", virq_n); end
        bus_write(XCSR, 16'o000000, 1'b0); clks(2);
        checks++;
        if (virq_n !== 1'b1) begin errors++; $display("FAIL txirq_ie_clear got virq_n=%b, need 1", virq_n); end
    endtask

    task automatic test_reset_midtx;
        logic [15:0] d;
        bus_write(XCSR, 16'o000100, 1'b0);
        bus_write(XBUF, 16'o000000, 1'b0);
        clks(3 * B);
        checks++;
        if ({txd, virq_n} !== 2'b00) begin
            errors++; $display("FAIL midtx_pre got txd=%b virq_n=%b, need 0 0", txd, virq_n);
        end
        init_n = 1'b0; #1;
        checks++;
        if ({txd, virq_n} !== 2'b11) begin
            errors++; $display("FAIL midtx_reset got txd=%b virq_n=%b, need 1 1", txd, virq_n);
        end
        clks(2); init_n = 1'b1;
        m_done = 0; m_err = 0; m_ie = 0; m_data = 0;
        clks(3);
        bus_read(XCSR, d);
        checks++;
        if (d !== 16'o000200) begin errors++; $display("FAIL midtx_xcsr got %o, need 000200", d); end
    endtask

    task automatic test_rx_irq;
        logic [15:0] d, v;
        bus_write(RCSR, 16'o000100, 1'b0); m_ie = 1;
        send_rx(8'h55, 1'b1);
        bus_read(RCSR, d);
        checks++;
        if (d !== {8'h00, m_done, m_ie, 6'b0}) begin errors++; $display("FAIL rx_rcsr got %o, need 000300", d); end
        checks++;
        if (virq_n !== 1'b0) begin errors++; $display("FAIL rx_virq got %b, need 0", virq_n); end
        iak(v);
        checks++;
        if (v !== 16'o000060) begin errors++; $display("FAIL rx_vector got %o, need 000060", v); end
        checks++;
        if (virq_n !== 1'b1) begin errors++; $display("FAIL rx_served got virq_n=%b, need 1", virq_n); end
        bus_read(RBUF, d);
        checks++;
        if (d !== 16'o000125) begin errors++; $display("FAIL rx_rbuf got %o, need 000125", d); end
        m_done = 0; m_err = 0;
        bus_read(RCSR, d);
        checks++;
        if (d !== 16'o000100) begin errors++; $display("FAIL rx_cleared got %o, need 000100", d); end
        bus_write(RCSR, 16'o000000, 1'b0); m_ie = 0;
    endtask

    task automatic test_rx_random;
        logic [15:0] d;
        logic [7:0]  c;
        logic        stop;
        for (int k = 0; k < 6; k++) begin
            c = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_rx(c, stop);
            if ($urandom_range(0, 1) == 1) begin
                bus_read(RBUF, d);
                checks++;
                if (d !== {m_err, 7'b0, m_data}) begin
                    errors++; $display("FAIL rx_rand_rbuf k=%0d got %o, need %o", k, d, {m_err, 7'b0, m_data});
                end
                m_done = 0; m_err = 0;
            end
        end
        bus_read(RCSR, d);
        checks++;
        if (d !== {8'h00, m_done, m_ie, 6'b0}) begin
            errors++; $display("FAIL rx_rand_rcsr got %o, need %o", d, {8'h00, m_done, m_ie, 6'b0});
        end
        send_rx(8'h3C, 1'b1);
        send_rx(8'hC3, 1'b1);
        bus_read(RBUF, d);
        checks++;
        if (d !== (16'o100000 | 16'h00C3)) begin
            errors++; $display("FAIL rx_overrun got %o, need %o", d, 16'o100000 | 16'h00C3);
        end
        m_done = 0; m_err = 0;
    endtask

    task automatic test_decode;
        logic [15:0] d;
        bit          bad;
        ad_in_n = ~16'o177570; clks(1); sync_n = 1'b0; clks(4);
        ad_in_n = '1; din_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (rply_n !== 1'b1 || ad_oe !== 1'b0) bad = 1; end
        din_n = 1'b1; sync_n = 1'b1; clks(3);
        checks++;
        if (bad) begin errors++; $display("FAIL unselected_access got reply or oe, need none"); end
        bus_write(BASE + 16'd1, 16'o000100, 1'b1);
        bus_read(RCSR, d);
        checks++;
        if (d !== 16'o000000) begin errors++; $display("FAIL odd_byte_write got %o, need 000000", d); end
        bus_write(BASE, 16'o000100, 1'b1);
        bus_read(RCSR, d);
        checks++;
        if (d !== 16'o000100) begin errors++; $display("FAIL even_byte_write got %o, need 000100", d); end
        bus_write(RCSR, 16'o000000, 1'b0);
    endtask

    task automatic test_daisy;
        logic [15:0] v;
        iako_n = 1'b0; clks(4);
        checks++;
        if (iako_out_n !== 1'b0) begin errors++; $display("FAIL daisy_pass got %b, need 0", iako_out_n); end
        din_n = 1'b0; clks(6);
        checks++;
        if ({ad_oe, rply_n} !== 2'b01) begin
            errors++; $display("FAIL daisy_passive got oe=%b rply=%b, need 0 1", ad_oe, rply_n);
        end
        din_n = 1'b1; iako_n = 1'b1; clks(4);
        checks++;
        if (iako_out_n !== 1'b1) begin errors++; $display("FAIL daisy_release got %b, need 1", iako_out_n); end
        bus_write(XCSR, 16'o000100, 1'b0); clks(2);
        iako_n = 1'b0; clks(4);
        checks++;
        if (iako_out_n !== 1'b1) begin errors++; $display("FAIL daisy_block got %b, need 1", iako_out_n); end
        iako_n = 1'b1; clks(2);
        iak(v);
        checks++;
        if (v !== 16'o000064) begin errors++; $display("FAIL daisy_vector got %o, need 000064", v); end
        bus_write(XCSR, 16'o000000, 1'b0);
    endtask

    initial begin
        init_n = 1'b0; sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1;
        wtbt_n = 1'b1; iako_n = 1'b1; rxd = 1'b1; ad_in_n = '1;
        m_done = 0; m_err = 0; m_ie = 0; m_data = 0;
        clks(3);
        test_reset();
        test_tx();
        test_back_to_back();
        test_tx_irq();
        test_reset_midtx();
        test_rx_irq();
        test_rx_random();
        test_decode();
        test_daisy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
